// File: rtl/td4x_pkg.sv
// Shared definitions for the TD4X core: opcode encodings, core state type
// and helpers that split an instruction word into opcode and immediate.
package td4x_pkg;

    localparam int MAX_DATA_W  = 32;
    localparam int MAX_INSTR_W = MAX_DATA_W + 4;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_HLT    = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic {
        CORE_RUN  = 1'b0,
        CORE_HALT = 1'b1
    } core_state_t;

    // Callers zero-extend their word to MAX_INSTR_W and pass their data width.
    function automatic logic [3:0] instr_opcode(input logic [MAX_INSTR_W-1:0] word,
                                                input int data_w);
        return word[data_w +: 4];
    endfunction

    function automatic logic [MAX_DATA_W-1:0] instr_imm(input logic [MAX_INSTR_W-1:0] word,
                                                        input int data_w);
        logic [MAX_INSTR_W-1:0] mask;
        mask = (MAX_INSTR_W'(1) << data_w) - MAX_INSTR_W'(1);
        return MAX_DATA_W'(word & mask);
    endfunction

endpackage

// File: rtl/td4x_timing.sv
// Execution-enable generation for the TD4X core: run-mode prescaler,
// single-step rising-edge detector and the in_port two-flop synchroniser.
module td4x_timing
    import td4x_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int CLK_DIV = 2500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              halted,
    input  logic [DATA_W-1:0] in_port,
    output logic              ex,
    output logic [DATA_W-1:0] in_sync
);

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]  count;
    logic              step_q;
    logic [DATA_W-1:0] in_meta;
    logic              tick;
    logic              step_rise;

    // Holding the count at zero while stopped makes the first tick after
    // entering run mode land a full CLK_DIV clocks later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!run || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_q  <= 1'b0;
            in_meta <= '0;
            in_sync <= '0;
        end else begin
            step_q  <= step;
            in_meta <= in_port;
            in_sync <= in_meta;
        end
    end

    assign tick      = run && (count == CNT_LAST);
    assign step_rise = step && !step_q;
    assign ex        = !halted && (run ? tick : step_rise);

endmodule

// File: rtl/td4x_core.sv
// TD4-class accumulator CPU: A/B registers, carry, output latch and PC
// fetching from an external combinational ROM, with run/step/halt control.
module td4x_core
    import td4x_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 4,
    parameter int CLK_DIV = 2500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic [DATA_W-1:0] in_port,
    input  logic [DATA_W+3:0] instr,
    output logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] out_port,
    output logic              carry,
    output logic              halted,
    output logic              retire
);

    core_state_t       state;
    core_state_t       state_next;
    logic              ex;
    logic [DATA_W-1:0] in_sync;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W:0]   sum_a;
    logic [DATA_W:0]   sum_b;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;
    logic [DATA_W-1:0] out_next;
    logic [ADDR_W-1:0] pc_next;
    logic              carry_next;

    td4x_timing #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .step    (step),
        .halted  (halted),
        .in_port (in_port),
        .ex      (ex),
        .in_sync (in_sync)
    );

    assign opcode = instr_opcode(MAX_INSTR_W'(instr), DATA_W);
    assign imm    = DATA_W'(instr_imm(MAX_INSTR_W'(instr), DATA_W));
    assign sum_a  = {1'b0, a_reg} + {1'b0, imm};
    assign sum_b  = {1'b0, b_reg} + {1'b0, imm};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CORE_RUN;
        end else begin
            state <= state_next;
        end
    end

    // HALT is a one-way trip; only reset returns the core to CORE_RUN.
    always_comb begin
        state_next = state;
        if (state == CORE_RUN && ex && opcode == OP_HLT) begin
            state_next = CORE_HALT;
        end
    end

    always_comb begin
        halted = (state == CORE_HALT);
    end

    // Carry is cleared by every executed instruction except the two ADDs;
    // JNC reads the carry register value from before this edge.
    always_comb begin
        a_next     = a_reg;
        b_next     = b_reg;
        out_next   = out_port;
        pc_next    = iaddr;
        carry_next = carry;
        if (ex) begin
            carry_next = 1'b0;
            pc_next    = iaddr + ADDR_W'(1);
            case (opcode)
                OP_ADD_A: begin
                    a_next     = sum_a[DATA_W-1:0];
                    carry_next = sum_a[DATA_W];
                end
                OP_ADD_B: begin
                    b_next     = sum_b[DATA_W-1:0];
                    carry_next = sum_b[DATA_W];
                end
                OP_MOV_AI: a_next   = imm;
                OP_MOV_BI: b_next   = imm;
                OP_MOV_AB: a_next   = b_reg;
                OP_MOV_BA: b_next   = a_reg;
                OP_IN_A:   a_next   = in_sync;
                OP_IN_B:   b_next   = in_sync;
                OP_OUT_I:  out_next = imm;
                OP_OUT_B:  out_next = b_reg;
                OP_JMP:    pc_next  = imm[ADDR_W-1:0];
                OP_JNC: begin
                    if (!carry) begin
                        pc_next = imm[ADDR_W-1:0];
                    end
                end
                OP_HLT:    pc_next  = iaddr;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            out_port <= '0;
            iaddr    <= '0;
            carry    <= 1'b0;
            retire   <= 1'b0;
        end else begin
            a_reg    <= a_next;
            b_reg    <= b_next;
            out_port <= out_next;
            iaddr    <= pc_next;
            carry    <= carry_next;
            retire   <= ex;
        end
    end

endmodule

// File: doc/td4x_core.md
# td4x_core

Parametrised TD4-class accumulator CPU core: registers A and B, a true carry flag, an output latch, and a program counter fetching from an external combinational instruction ROM. It generalises the 4-bit TD4 datapath to DATA_W/ADDR_W and adds a built-in execution prescaler, run/single-step control, a HALT instruction, a synchronised input port and a retire strobe. It sits between the board top level (buttons, LEDs, clock) and a `td4x_rom` program image.

## Interface
- DATA_W, 4: width of A, B, immediate, in/out ports; must be >= ADDR_W
- ADDR_W, 4: program counter width; ROM depth = 2^ADDR_W
- CLK_DIV, 2500000: clocks per execution tick when running; 1 = every clock
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- run  in  1  1 = free-run on prescaler ticks; 0 = single-step mode
- step  in  1  single-step request (level sampled, rising-edge detected internally), ignored when run=1
- in_port  in  DATA_W  external input (buttons), asynchronous
- instr  in  4+DATA_W  instruction at iaddr: [DATA_W+3:DATA_W] opcode, [DATA_W-1:0] immediate
- iaddr  out  ADDR_W  program counter
- out_port  out  DATA_W  output latch
- carry  out  1  carry flag
- halted  out  1  core in HALT state
- retire  out  1  one-clock pulse on the clock an instruction executes

## Operation
- Reset (rst_n=0 at a clock edge): A, B, out_port, iaddr, carry, halted, retire, prescaler, step edge detector, input synchroniser all 0. Reset dominates every other input.
- Execute enable `ex` = ~halted & (run ? tick : step_rise). On `ex`, the instruction on `instr` executes, all register updates land on that edge, and retire=1 for that clock.
- Opcodes (im = immediate, sum = {1'b0,X}+im, DATA_W+1 bits):
  - 0000 ADD A,im: A<=sum[DATA_W-1:0], carry<=sum[DATA_W]
  - 0101 ADD B,im: same on B
  - 0011 MOV A,im; 0111 MOV B,im; 0001 MOV A,B; 0100 MOV B,A
  - 0010 IN A; 0110 IN B: load synchronised in_port
  - 1011 OUT im; 1001 OUT B
  - 1111 JMP im: iaddr<=im[ADDR_W-1:0]
  - 1110 JNC im: if carry==0 jump to im, else iaddr+1
  - 1000 HLT: halted<=1, iaddr unchanged
  - 1010, 1100, 1101: NOP
- Every opcode except ADD clears carry (JNC tests the pre-execution carry value).
- Non-jump, non-HLT: iaddr<=iaddr+1, wrapping 2^ADDR_W-1 -> 0.
- HALT is left only by reset.

## Timing
- Prescaler counts 0..CLK_DIV-1 continuously while run=1; tick when count==CLK_DIV-1, count then returns to 0. run=0 holds count at 0, so first tick after run 0->1 comes CLK_DIV clocks later.
- in_port: 2-flop synchroniser; a change is visible to IN after 2 clocks.
- step: registered once; step_rise = step & ~step_q; execution on the clock after the rising edge is sampled. Held step executes once.
- retire coincides with the iaddr/register update edge; never two retires closer than CLK_DIV clocks in run mode.
- Fetch is combinational: instr must be valid in the same cycle iaddr changes; no fetch latency.
- run toggled mid-way: mode change takes effect on the next clock; pending step edge during run=1 is discarded.

## Structure
- Package `td4x_pkg`: opcode localparams (OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI, OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI, OP_HLT, OP_OUT_B, OP_OUT_I, OP_JNC, OP_JMP), instruction field-extraction functions.
- Sub-module `td4x_rom` (parameters DATA_W, ADDR_W, INIT_FILE; $readmemb image, combinational read) instantiated at top level, not inside the core.
- Prescaler and step edge detector live in the core.

## Test plan
- CLK_DIV=1, run=1, program MOV A,3; ADD A,14; JNC 0; OUT 15; HLT -> A=1, carry=1 after ADD, JNC falls through, out_port=15, halted=1, iaddr stuck at 4.
- Program ADD A,1 x15 then JMP 0, 15 ADDs from A=0 -> A=15 carry=0; 16th ADD -> A=0 carry=1; next MOV clears carry.
- run=0, pulse step 3 times (step held 5 clocks each) -> exactly 3 retire pulses, iaddr=3.
- CLK_DIV=4 -> retire every 4th clock; first retire 4 clocks after reset release.
- in_port=4'b1010 applied, IN B; OUT B 2 clocks later -> out_port=1010; applied 1 clock before IN -> old value loaded.
- Reset asserted mid-run and while halted -> next edge all outputs 0, halted=0; PC wrap: 16 NOPs from 0 -> iaddr=0.
